tile_map_arbiter: RTL and testbench

//   Shares the single-port 40x30 tile-map RAM (1200 x 4-bit codes: 0 empty, 1 wall, 2 dot, 3 power dot,
//   4 pac-man, 5-8 ghosts) between the VGA tile fetcher and N game-logic movers (pac-man, ghosts).

---
 rtl/tile_map_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_tile_map_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_arbiter.sv
// tile_map_arbiter
// Shares one single-port tile-map RAM between the VGA tile fetcher and N_REQ
// game-logic movers. One access is issued per cycle: video normally wins,
// movers rotate round-robin, and a starvation counter steals one video slot
// after STARVE_LIM consecutive video wins while a mover is waiting.
// Pipeline: decide (T) -> issue on mem_* (T+1) -> read return (T+2).
module tile_map_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 4,
  parameter int DEPTH      = 1200,
  parameter int STARVE_LIM = 8
) (
  input  logic                       clk,
  input  logic                       reset,      // asynchronous, active-low
  input  logic                       vid_req,
  input  logic [ADDR_W-1:0]          vid_addr,
  output logic [DATA_W-1:0]          vid_data,
  output logic                       vid_valid,
  output logic                       vid_stall,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [DATA_W-1:0]          rdata,
  output logic [N_REQ-1:0]           rvalid,
  output logic                       err_oob,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_we,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int                PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [31:0]       DEPTH_U   = 32'(DEPTH);
  localparam logic [7:0]        STARVE_C  = 8'(STARVE_LIM);
  localparam logic [DATA_W-1:0] WALL_CODE = DATA_W'(1);

  // Unpacked views of the packed mover buses
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Registered state: issue-cycle outputs, arbitration state, return tags
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              mem_we_q,    mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [N_REQ-1:0]  gnt_q,       gnt_d;
  logic              vid_stall_q, vid_stall_d;
  logic              err_oob_q,   err_oob_d;
  logic [PTR_W-1:0]  ptr_q,       ptr_d;
  logic [7:0]        starve_q,    starve_d;
  // Issue-stage tags: which client's read is on mem_* this cycle
  logic              iss_vid_q,   iss_vid_d;
  logic [N_REQ-1:0]  iss_mov_q,   iss_mov_d;
  logic              iss_oob_q,   iss_oob_d;
  // Return-stage tags: which client owns mem_rdata this cycle
  logic              ret_vid_q,   ret_vid_d;
  logic [N_REQ-1:0]  ret_mov_q,   ret_mov_d;
  logic              ret_oob_q,   ret_oob_d;

  // Decision-stage signals
  logic [N_REQ-1:0]  req_live;
  logic              mov_pend;
  logic              vid_win;
  logic              mov_hit;
  logic              mov_win;
  logic [PTR_W-1:0]  mov_idx;
  logic [ADDR_W-1:0] mov_addr;
  logic              mov_we;
  logic [DATA_W-1:0] mov_wdata;
  logic              vid_oob;
  logic              mov_oob;

  // Pick this cycle's winner; a mover being granted right now is not re-eligible
  always_comb begin
    req_live = req & ~gnt_q;
    mov_pend = |req_live;
    // Video only yields when the guard has tripped and a mover is actually waiting
    vid_win  = vid_req && ((starve_q < STARVE_C) || !mov_pend);
    mov_hit  = 1'b0;
    mov_idx  = ptr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!mov_hit && req_live[(int'(ptr_q) + k) % N_REQ]) begin
        mov_hit = 1'b1;
        mov_idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
    mov_win   = !vid_win && mov_hit;
    mov_addr  = addr_arr[mov_idx];
    mov_we    = req_we[mov_idx];
    mov_wdata = wdata_arr[mov_idx];
    vid_oob   = ({{(32-ADDR_W){1'b0}}, vid_addr} >= DEPTH_U);
    mov_oob   = ({{(32-ADDR_W){1'b0}}, mov_addr} >= DEPTH_U);
  end

  // Next-state: issue registers, RR pointer, starvation counter, tag pipeline
  always_comb begin
    mem_addr_d  = mem_addr_q;     // address holds across idle cycles
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    gnt_d       = '0;
    vid_stall_d = 1'b0;
    err_oob_d   = 1'b0;
    ptr_d       = ptr_q;
    starve_d    = starve_q;
    iss_vid_d   = 1'b0;
    iss_mov_d   = '0;
    iss_oob_d   = 1'b0;
    ret_vid_d   = iss_vid_q;
    ret_mov_d   = iss_mov_q;
    ret_oob_d   = iss_oob_q;

    if (vid_win) begin
      mem_addr_d = vid_addr;
      err_oob_d  = vid_oob;
      iss_vid_d  = 1'b1;
      iss_oob_d  = vid_oob;
      // vid_win with a waiting mover implies starve_q < STARVE_C, so no overflow
      if (mov_pend) begin
        starve_d = starve_q + 8'd1;
      end
    end else if (mov_win) begin
      mem_addr_d     = mov_addr;
      mem_we_d       = mov_we && !mov_oob;   // out-of-range writes never reach the RAM
      mem_wdata_d    = mov_wdata;
      gnt_d[mov_idx] = 1'b1;
      ptr_d          = mov_idx;
      starve_d       = '0;
      vid_stall_d    = vid_req;              // video request lost to the guard
      err_oob_d      = mov_oob;
      if (!mov_we) begin
        iss_mov_d[mov_idx] = 1'b1;
        iss_oob_d          = mov_oob;
      end
    end
  end

  // State register; reset discards any in-flight return
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      gnt_q       <= '0;
      vid_stall_q <= 1'b0;
      err_oob_q   <= 1'b0;
      ptr_q       <= PTR_W'(N_REQ - 1);  // req[0] wins the first mover decision
      starve_q    <= '0;
      iss_vid_q   <= 1'b0;
      iss_mov_q   <= '0;
      iss_oob_q   <= 1'b0;
      ret_vid_q   <= 1'b0;
      ret_mov_q   <= '0;
      ret_oob_q   <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      gnt_q       <= gnt_d;
      vid_stall_q <= vid_stall_d;
      err_oob_q   <= err_oob_d;
      ptr_q       <= ptr_d;
      starve_q    <= starve_d;
      iss_vid_q   <= iss_vid_d;
      iss_mov_q   <= iss_mov_d;
      iss_oob_q   <= iss_oob_d;
      ret_vid_q   <= ret_vid_d;
      ret_mov_q   <= ret_mov_d;
      ret_oob_q   <= ret_oob_d;
    end
  end

  // Output drive; return data is gated so the buses stay 0 without a pulse
  always_comb begin
    mem_addr  = mem_addr_q;
    mem_we    = mem_we_q;
    mem_wdata = mem_wdata_q;
    gnt       = gnt_q;
    vid_stall = vid_stall_q;
    err_oob   = err_oob_q;
    vid_valid = ret_vid_q;
    rvalid    = ret_mov_q;
    vid_data  = '0;
    rdata     = '0;
    if (ret_vid_q) begin
      vid_data = ret_oob_q ? WALL_CODE : mem_rdata;
    end
    if (|ret_mov_q) begin
      rdata = ret_oob_q ? WALL_CODE : mem_rdata;
    end
  end

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Directed bench for tile_map_arbiter with a behavioural synchronous-read RAM.
module tb_tile_map_arbiter;

  logic        clk;
  logic        reset;
  logic        vid_req;
  logic [10:0] vid_addr;
  logic [3:0]  vid_data;
  logic        vid_valid;
  logic        vid_stall;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [43:0] req_addr;
  logic [15:0] req_wdata;
  logic [3:0]  gnt;
  logic [3:0]  rdata;
  logic [3:0]  rvalid;
  logic        err_oob;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;

  logic [3:0]  ram [0:2047];

  int n_chk  = 0;
  int n_fail = 0;

  tile_map_arbiter #(
    .N_REQ(4), .ADDR_W(11), .DATA_W(4), .DEPTH(1200), .STARVE_LIM(8)
  ) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_stall(vid_stall),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .err_oob(err_oob),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, one-cycle synchronous read
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_vid;
    int          idx;
    logic        we;
    logic [10:0] addr;
    logic [3:0]  wdata;
    logic        exp_oob;
    logic        exp_we;
    logic [3:0]  exp_data;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [3:0] exp_rr_a [5];
    logic [3:0] exp_gnt;
    logic [3:0] req_v;
    logic [3:0] prev_g;

    vid_req = 0; vid_addr = '0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    reset = 1'b0;
    for (int i = 0; i < 2048; i++) ram[i] <= 4'd0;
    ram[0]    <= 4'd8;
    ram[41]   <= 4'd2;
    ram[42]   <= 4'd3;
    ram[100]  <= 4'd3;
    ram[1200] <= 4'd6;
    ram[1205] <= 4'd5;
    ram[1500] <= 4'd7;

    //            vid  idx we    addr      wdata  oob   we_e  data
    vecs[0] = '{1'b0, 0, 1'b0, 11'd41,   4'd0, 1'b0, 1'b0, 4'd2};
    vecs[1] = '{1'b0, 1, 1'b1, 11'd737,  4'd4, 1'b0, 1'b1, 4'd0};
    vecs[2] = '{1'b0, 1, 1'b0, 11'd737,  4'd0, 1'b0, 1'b0, 4'd4};
    vecs[3] = '{1'b0, 3, 1'b0, 11'd1200, 4'd0, 1'b1, 1'b0, 4'd1};
    vecs[4] = '{1'b0, 3, 1'b1, 11'd1205, 4'd3, 1'b1, 1'b0, 4'd0};
    vecs[5] = '{1'b1, 0, 1'b0, 11'd100,  4'd0, 1'b0, 1'b0, 4'd3};
    vecs[6] = '{1'b1, 0, 1'b0, 11'd1500, 4'd0, 1'b1, 1'b0, 4'd1};
    vecs[7] = '{1'b0, 2, 1'b1, 11'd1199, 4'd7, 1'b0, 1'b1, 4'd0};
    vecs[8] = '{1'b0, 2, 1'b0, 11'd1199, 4'd0, 1'b0, 1'b0, 4'd7};
    vecs[9] = '{1'b0, 0, 1'b0, 11'd0,    4'd0, 1'b0, 1'b0, 4'd8};

    // Reset state
    #12;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_vid_valid", 32'(vid_valid), 0);
    chk("rst_vid_stall", 32'(vid_stall), 0);
    chk("rst_err_oob", 32'(err_oob), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_rdata", 32'(rdata), 0);
    #5 reset = 1'b1;
    step();

    // Round-robin: all four request, each drops after its grant
    exp_rr_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    for (int i = 0; i < 4; i++) req_addr[i*11 +: 11] = 11'(10 + i);
    req_v = 4'b1111; prev_g = '0; req = req_v;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr_a%0d", k), 32'(gnt), 32'(exp_rr_a[k]));
      req_v = req_v & ~prev_g;
      prev_g = gnt;
      req = req_v;
    end
    req = 4'b1001;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rr_b%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h8);
    end
    req = '0;
    repeat (3) step();

    // Table of single transactions from idle
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].is_vid) begin
        vid_req = 1'b1; vid_addr = vecs[v].addr;
      end else begin
        req[vecs[v].idx] = 1'b1;
        req_we[vecs[v].idx] = vecs[v].we;
        req_addr[vecs[v].idx*11 +: 11] = vecs[v].addr;
        req_wdata[vecs[v].idx*4 +: 4] = vecs[v].wdata;
      end
      exp_gnt = vecs[v].is_vid ? 4'b0000 : 4'(1 << vecs[v].idx);
      step();  // issue
      vid_req = 1'b0;
      chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(exp_gnt));
      chk($sformatf("v%0d_mem_addr", v), 32'(mem_addr), 32'(vecs[v].addr));
      chk($sformatf("v%0d_mem_we", v), 32'(mem_we), 32'(vecs[v].exp_we));
      chk($sformatf("v%0d_err_oob", v), 32'(err_oob), 32'(vecs[v].exp_oob));
      chk($sformatf("v%0d_vid_stall", v), 32'(vid_stall), 0);
      if (vecs[v].exp_we) chk($sformatf("v%0d_mem_wdata", v), 32'(mem_wdata), 32'(vecs[v].wdata));
      step();  // return
      req = '0; req_we = '0;
      chk($sformatf("v%0d_rvalid", v), 32'(rvalid),
          (!vecs[v].is_vid && !vecs[v].we) ? 32'(exp_gnt) : 0);
      chk($sformatf("v%0d_vid_valid", v), 32'(vid_valid), 32'(vecs[v].is_vid));
      if (vecs[v].is_vid)
        chk($sformatf("v%0d_vid_data", v), 32'(vid_data), 32'(vecs[v].exp_data));
      else if (!vecs[v].we)
        chk($sformatf("v%0d_rdata", v), 32'(rdata), 32'(vecs[v].exp_data));
      step();  // idle: address holds, no pulses
      chk($sformatf("v%0d_idle_addr", v), 32'(mem_addr), 32'(vecs[v].addr));
      chk($sformatf("v%0d_idle_we", v), 32'(mem_we), 0);
      chk($sformatf("v%0d_idle_gnt", v), 32'(gnt), 0);
      chk($sformatf("v%0d_idle_rv", v), 32'(rvalid | 4'(vid_valid)), 0);
      $display("vec %0d done: vid=%0b idx=%0d we=%0b addr=%0d", v, vecs[v].is_vid,
               vecs[v].idx, vecs[v].we, vecs[v].addr);
    end
    chk("oob_write_ram_unchanged", 32'(ram[1205]), 5);

    // Starvation: video every cycle, req[2] pending
    vid_req = 1'b1; vid_addr = 11'd100;
    req[2] = 1'b1; req_we[2] = 1'b0; req_addr[2*11 +: 11] = 11'd42;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk($sformatf("st%0d_gnt", k), 32'(gnt), (k == 9) ? 32'h4 : 0);
      chk($sformatf("st%0d_stall", k), 32'(vid_stall), (k == 9) ? 1 : 0);
      chk($sformatf("st%0d_vid_valid", k), 32'(vid_valid), (k >= 2 && k != 10) ? 1 : 0);
      chk($sformatf("st%0d_rvalid", k), 32'(rvalid), (k == 10) ? 32'h4 : 0);
      if (k == 10) begin
        chk("st_rdata", 32'(rdata), 3);
        req = '0;
      end
    end
    vid_req = 1'b0;
    repeat (3) step();

    // Async reset between issue and return
    req[1] = 1'b1; req_addr[1*11 +: 11] = 11'd41;
    step();
    chk("ar_gnt_before", 32'(gnt), 32'h2);
    #1 reset = 1'b0;
    #1;
    chk("ar_gnt_async", 32'(gnt), 0);
    chk("ar_mem_addr_async", 32'(mem_addr), 0);
    req = '0;
    step();
    #3 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("ar_rvalid%0d", k), 32'(rvalid), 0);
      chk($sformatf("ar_vid_valid%0d", k), 32'(vid_valid), 0);
    end
    req = 4'b1111;
    step();
    chk("ar_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
